// File: rtl/fft8_frame_loader.sv
// ============================================================================
// Module   : fft8_frame_loader
// Summary  : Packs streamed complex samples into 8-lane frames through a
//            ping-pong buffer and issues them to an 8-point FFT/IFFT core.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fft8_frame_loader #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_r,
    input  logic [DATA_WIDTH-1:0]   in_i,
    input  logic                    in_last,
    input  logic                    issue_en,
    output logic                    fft_next,
    output logic [8*DATA_WIDTH-1:0] fft_r,
    output logic [8*DATA_WIDTH-1:0] fft_i,
    output logic                    err_short,
    output logic [15:0]             frame_count
);

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NEXT = 2'd1,
        ST_DATA = 2'd2
    } issue_state_t;

    bank_state_t  r_bank_st [2];
    issue_state_t r_state;
    logic         r_alive;
    logic         r_fill_bank;
    logic         r_issue_bank;
    logic [2:0]   r_fill_idx;
    logic         r_fft_next;
    logic         r_err_short;
    logic [15:0]  r_frame_count;

    logic         w_accept;
    logic         w_close;
    logic         w_short;
    logic         w_load;

    // r_alive keeps in_ready low until the first edge after reset release.
    assign in_ready    = r_alive && (r_bank_st[r_fill_bank] != BANK_FULL);
    assign w_accept    = in_valid && in_ready;
    assign w_short     = in_last && (r_fill_idx != 3'd7);
    assign w_close     = in_last || (r_fill_idx == 3'd7);
    assign w_load      = (r_state == ST_NEXT);

    assign fft_next    = r_fft_next;
    assign err_short   = r_err_short;
    assign frame_count = r_frame_count;

    for (genvar gk = 0; gk < 8; gk++) begin : g_lane
        localparam logic [2:0] c_lane = 3'(gk);

        logic [DATA_WIDTH-1:0] r_bank_r [2];
        logic [DATA_WIDTH-1:0] r_bank_i [2];
        logic [DATA_WIDTH-1:0] r_out_r;
        logic [DATA_WIDTH-1:0] r_out_i;

        // Lanes past a short close are zeroed so stale samples never issue.
        always_ff @(posedge clk) begin
            if (w_accept) begin
                if (r_fill_idx == c_lane) begin
                    r_bank_r[r_fill_bank] <= in_r;
                    r_bank_i[r_fill_bank] <= in_i;
                end else if (w_short && (r_fill_idx < c_lane)) begin
                    r_bank_r[r_fill_bank] <= '0;
                    r_bank_i[r_fill_bank] <= '0;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_out_r <= '0;
                r_out_i <= '0;
            end else if (w_load) begin
                r_out_r <= r_bank_r[r_issue_bank];
                r_out_i <= r_bank_i[r_issue_bank];
            end
        end

        assign fft_r[gk*DATA_WIDTH +: DATA_WIDTH] = r_out_r;
        assign fft_i[gk*DATA_WIDTH +: DATA_WIDTH] = r_out_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alive       <= 1'b0;
            r_fill_bank   <= 1'b0;
            r_fill_idx    <= 3'd0;
            r_issue_bank  <= 1'b0;
            r_bank_st[0]  <= BANK_FREE;
            r_bank_st[1]  <= BANK_FREE;
            r_state       <= ST_IDLE;
            r_fft_next    <= 1'b0;
            r_err_short   <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_alive     <= 1'b1;
            r_err_short <= w_accept && w_short;
            r_fft_next  <= 1'b0;

            if (w_accept) begin
                if (w_close) begin
                    r_bank_st[r_fill_bank] <= BANK_FULL;
                    r_fill_bank            <= ~r_fill_bank;
                    r_fill_idx             <= 3'd0;
                end else begin
                    r_bank_st[r_fill_bank] <= BANK_FILLING;
                    r_fill_idx             <= r_fill_idx + 3'd1;
                end
            end

            // The issue bank is FULL here, so it never collides with the fill update.
            case (r_state)
                ST_IDLE: begin
                    if ((r_bank_st[r_issue_bank] == BANK_FULL) && issue_en) begin
                        r_state    <= ST_NEXT;
                        r_fft_next <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    r_state       <= ST_DATA;
                    r_frame_count <= r_frame_count + 16'd1;
                end
                ST_DATA: begin
                    r_bank_st[r_issue_bank] <= BANK_FREE;
                    r_issue_bank            <= ~r_issue_bank;
                    if ((r_bank_st[~r_issue_bank] == BANK_FULL) && issue_en) begin
                        r_state    <= ST_NEXT;
                        r_fft_next <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft8_frame_loader.sv
// ============================================================================
// Module   : tb_fft8_frame_loader
// Summary  : Directed self-checking bench for fft8_frame_loader.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fft8_frame_loader;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_r = '0;
    logic [DW-1:0] in_i = '0;
    logic          in_last = 1'b0;
    logic          issue_en = 1'b0;
    logic          fft_next;
    logic [8*DW-1:0] fft_r;
    logic [8*DW-1:0] fft_i;
    logic          err_short;
    logic [15:0]   frame_count;

    int total = 0;
    int bad   = 0;

    fft8_frame_loader #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_r        (in_r),
        .in_i        (in_i),
        .in_last     (in_last),
        .issue_en    (issue_en),
        .fft_next    (fft_next),
        .fft_r       (fft_r),
        .fft_i       (fft_i),
        .err_short   (err_short),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] ramp(input int base, input int step);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(base + step * k);
        return v;
    endfunction

    // Offer one sample and return 1 ns after the edge that accepts it.
    task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_r     = r;
        in_i     = i;
        in_last  = last;
        while (!in_ready && n < 64) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout observed=in_ready_low required=accept");
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int br, input int sr, input int bi, input int si, input int first);
        for (int k = first; k < 8; k++) send(16'(br + sr * k), 16'(bi + si * k), 1'b0);
    endtask

    initial begin
        int gaps [8];
        gaps = '{1, 0, 2, 0, 0, 3, 1, 0};

        // Reset state
        #1 reset = 1'b1;
        #11;
        chk("rst_ready", 128'(in_ready), 128'd0);
        chk("rst_next", 128'(fft_next), 128'd0);
        chk("rst_count", 128'(frame_count), 128'd0);
        chk("rst_fft_r", fft_r, 128'd0);
        chk("rst_err", 128'(err_short), 128'd0);
        tick();
        tick();
        chk("rst_ready_held", 128'(in_ready), 128'd0);
        reset = 1'b0;
        chk("rel_ready_low", 128'(in_ready), 128'd0);
        tick();
        chk("rel_ready_high", 128'(in_ready), 128'd1);

        // Basic frame
        issue_en = 1'b1;
        send_frame(0, 1, 0, -1, 0);
        chk("basic_next_early", 128'(fft_next), 128'd0);
        tick();
        chk("basic_next", 128'(fft_next), 128'd1);
        tick();
        chk("basic_next_drop", 128'(fft_next), 128'd0);
        chk("basic_r", fft_r, ramp(0, 1));
        chk("basic_i", fft_i, ramp(0, -1));
        chk("basic_count", 128'(frame_count), 128'd1);

        // Bubbles
        for (int k = 0; k < 8; k++) begin
            repeat (gaps[k]) tick();
            send(16'(k), 16'(-k), 1'b0);
        end
        chk("bub_next_early", 128'(fft_next), 128'd0);
        tick();
        chk("bub_next", 128'(fft_next), 128'd1);
        tick();
        chk("bub_r", fft_r, ramp(0, 1));
        chk("bub_i", fft_i, ramp(0, -1));
        chk("bub_count", 128'(frame_count), 128'd2);

        // Short frame
        send(16'd10, 16'd1, 1'b0);
        send(16'd11, 16'd1, 1'b0);
        send(16'd12, 16'd1, 1'b0);
        send(16'd13, 16'd1, 1'b1);
        chk("short_err", 128'(err_short), 128'd1);
        chk("short_next_early", 128'(fft_next), 128'd0);
        tick();
        chk("short_err_drop", 128'(err_short), 128'd0);
        chk("short_next", 128'(fft_next), 128'd1);
        tick();
        chk("short_r", fft_r, {64'h0, 16'd13, 16'd12, 16'd11, 16'd10});
        chk("short_i", fft_i, {64'h0, 64'h0001_0001_0001_0001});
        chk("short_count", 128'(frame_count), 128'd3);
        send_frame(20, 1, 100, 1, 0);
        tick();
        chk("after_short_next", 128'(fft_next), 128'd1);
        tick();
        chk("after_short_r", fft_r, ramp(20, 1));
        chk("after_short_i", fft_i, ramp(100, 1));
        chk("after_short_count", 128'(frame_count), 128'd4);

        // Backpressure
        issue_en = 1'b0;
        send_frame(32'h100, 1, 32'h200, 1, 0);
        send_frame(32'h110, 1, 32'h210, 1, 0);
        chk("bp_ready_drop", 128'(in_ready), 128'd0);
        repeat (3) tick();
        chk("bp_stall_next", 128'(fft_next), 128'd0);
        chk("bp_stall_ready", 128'(in_ready), 128'd0);
        in_valid = 1'b1;
        in_r     = 16'h120;
        in_i     = 16'h220;
        issue_en = 1'b1;
        tick();
        chk("bp_next0", 128'(fft_next), 128'd1);
        chk("bp_ready_still_low", 128'(in_ready), 128'd0);
        tick();
        chk("bp_gap", 128'(fft_next), 128'd0);
        chk("bp_f0_r", fft_r, ramp(32'h100, 1));
        chk("bp_f0_count", 128'(frame_count), 128'd5);
        tick();
        chk("bp_next1", 128'(fft_next), 128'd1);
        chk("bp_ready_rise", 128'(in_ready), 128'd1);
        send(16'h120, 16'h220, 1'b0);
        chk("bp_f1_r", fft_r, ramp(32'h110, 1));
        chk("bp_f1_i", fft_i, ramp(32'h210, 1));
        chk("bp_f1_count", 128'(frame_count), 128'd6);
        send_frame(32'h120, 1, 32'h220, 1, 1);
        tick();
        chk("bp_next2", 128'(fft_next), 128'd1);
        tick();
        chk("bp_f2_r", fft_r, ramp(32'h120, 1));
        chk("bp_f2_i", fft_i, ramp(32'h220, 1));
        chk("bp_f2_count", 128'(frame_count), 128'd7);

        // Mid-frame reset
        for (int k = 0; k < 5; k++) send(16'(32'h300 + k), 16'(32'h400 + k), 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mrst_next", 128'(fft_next), 128'd0);
        chk("mrst_fft_r", fft_r, 128'd0);
        chk("mrst_fft_i", fft_i, 128'd0);
        chk("mrst_count", 128'(frame_count), 128'd0);
        chk("mrst_ready", 128'(in_ready), 128'd0);
        tick();
        #3 reset = 1'b0;
        tick();
        chk("mrst_ready_back", 128'(in_ready), 128'd1);
        send_frame(32'h500, 1, 32'h600, -1, 0);
        chk("mrst_next_early", 128'(fft_next), 128'd0);
        tick();
        chk("mrst_next_pulse", 128'(fft_next), 128'd1);
        tick();
        chk("mrst_r", fft_r, ramp(32'h500, 1));
        chk("mrst_i", fft_i, ramp(32'h600, -1));
        chk("mrst_count1", 128'(frame_count), 128'd1);

        // Counter wrap via preload
        #1 force dut.r_frame_count = 16'hffff;
        #1 release dut.r_frame_count;
        #1;
        chk("wrap_preload", 128'(frame_count), 128'hffff);
        send_frame(32'h700, 2, 32'h7f0, -3, 0);
        tick();
        tick();
        chk("wrap_count", 128'(frame_count), 128'd0);
        chk("wrap_r", fft_r, ramp(32'h700, 2));
        chk("wrap_i", fft_i, ramp(32'h7f0, -3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
